// File: rtl/sata_crc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sata_crc_pkg
// Description : Shared constants and state encoding for the SATA CRC inserter.
// Revision    : 1.0 - initial release
// ============================================================================
package sata_crc_pkg;

    localparam logic [31:0] CRC_POLY         = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT_DEFAULT = 32'h52325032;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_CRC  = 2'd1,
        ST_DROP = 2'd2
    } crc_ins_state_t;

endpackage
`default_nettype wire

// File: rtl/crc_calculator.sv
`default_nettype none
// ============================================================================
// Module      : crc_calculator
// Description : Combinational MSB-first CRC update of one data word, no
//               reflection and no final XOR.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_calculator #(
    parameter int unsigned         DATAWIDTH  = 32,
    parameter int unsigned         CRCWIDTH   = 32,
    parameter logic [CRCWIDTH-1:0] POLYNOMIAL = 32'h04C11DB7
) (
    input  logic [DATAWIDTH-1:0] i_data,
    input  logic [CRCWIDTH-1:0]  i_crc,
    output logic [CRCWIDTH-1:0]  o_crc
);

    always_comb begin
        logic [CRCWIDTH-1:0] w_acc;
        logic                w_fb;
        w_acc = i_crc;
        for (int i = DATAWIDTH - 1; i >= 0; i--) begin
            w_fb  = w_acc[CRCWIDTH-1] ^ i_data[i];
            w_acc = {w_acc[CRCWIDTH-2:0], 1'b0} ^ (w_fb ? POLYNOMIAL : '0);
        end
        o_crc = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/sata_crc_inserter.sv
`default_nettype none
// ============================================================================
// Module      : sata_crc_inserter
// Description : Registers TX frame dwords, folds them into a running CRC-32
//               and appends the CRC dword after each frame's last data dword.
//               Optional frame length limit: SATA_CRC_INSERTER_LENGTH_LIMIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sata_crc_inserter
    import sata_crc_pkg::*;
#(
`ifdef SATA_CRC_INSERTER_LENGTH_LIMIT_EN
    parameter int unsigned MAXLEN   = 2064,
`endif
    parameter logic [31:0] CRC_INIT = CRC_INIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_dat,
    input  logic        i_val,
    input  logic        i_eop,
    output logic        i_rdy,
    output logic [31:0] o_dat,
    output logic        o_val,
    output logic        o_eop,
    input  logic        o_rdy,
    output logic        o_len_err
);

    crc_ins_state_t r_state;
    crc_ins_state_t w_state_nxt;

    logic [31:0] r_dat;
    logic        r_val;
    logic        r_eop;
    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;

    logic w_slot_free;
    logic w_ld_data;
    logic w_ld_crc;
    logic w_ovf;

    crc_calculator #(
        .DATAWIDTH  (32),
        .CRCWIDTH   (32),
        .POLYNOMIAL (CRC_POLY)
    ) u_crc (
        .i_data (i_dat),
        .i_crc  (r_crc),
        .o_crc  (w_crc_nxt)
    );

    assign w_slot_free = ~r_val | o_rdy;

`ifdef SATA_CRC_INSERTER_LENGTH_LIMIT_EN
    localparam logic [11:0] c_maxlen = 12'(MAXLEN);

    logic [11:0] r_cnt;
    logic        r_ovf;
    logic        r_len_err;
    logic        w_cnt_hit;

    assign w_cnt_hit = ((r_cnt + 12'd1) == c_maxlen);
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_DATA;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        i_rdy       = 1'b0;
        w_ld_data   = 1'b0;
        w_ld_crc    = 1'b0;
        w_ovf       = 1'b0;
        case (r_state)
            ST_DATA: begin
                i_rdy     = w_slot_free;
                w_ld_data = i_val & w_slot_free;
`ifdef SATA_CRC_INSERTER_LENGTH_LIMIT_EN
                w_ovf     = w_ld_data & ~i_eop & w_cnt_hit;
`endif
                if (w_ld_data & (i_eop | w_ovf)) w_state_nxt = ST_CRC;
            end
            ST_CRC: begin
                w_ld_crc = w_slot_free;
                if (w_slot_free) begin
`ifdef SATA_CRC_INSERTER_LENGTH_LIMIT_EN
                    w_state_nxt = r_ovf ? ST_DROP : ST_DATA;
`else
                    w_state_nxt = ST_DATA;
`endif
                end
            end
`ifdef SATA_CRC_INSERTER_LENGTH_LIMIT_EN
            ST_DROP: begin
                i_rdy = 1'b1;
                if (i_val & i_eop) w_state_nxt = ST_DATA;
            end
`endif
            default: w_state_nxt = ST_DATA;
        endcase
    end

    // The output register holds whenever the downstream stalls a valid beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dat <= '0;
            r_val <= 1'b0;
            r_eop <= 1'b0;
            r_crc <= CRC_INIT;
        end else if (w_ld_data) begin
            r_dat <= i_dat;
            r_val <= 1'b1;
            r_eop <= 1'b0;
            r_crc <= w_crc_nxt;
        end else if (w_ld_crc) begin
            r_dat <= r_crc;
            r_val <= 1'b1;
            r_eop <= 1'b1;
            r_crc <= CRC_INIT;
        end else if (w_slot_free) begin
            r_val <= 1'b0;
        end
    end

    assign o_dat = r_dat;
    assign o_val = r_val;
    assign o_eop = r_eop;

`ifdef SATA_CRC_INSERTER_LENGTH_LIMIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_ovf;
            if (w_ld_crc) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else if (w_ld_data) begin
                r_cnt <= r_cnt + 12'd1;
                if (w_ovf) r_ovf <= 1'b1;
            end
        end
    end

    assign o_len_err = r_len_err;
`else
    assign o_len_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sata_crc_inserter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sata_crc_inserter
// Description : Directed self-checking bench for sata_crc_inserter against a
//               bit-serial CRC-32 reference and a beat scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sata_crc_inserter;

    localparam logic [31:0] c_seed = 32'h52325032;
    localparam logic [31:0] c_poly = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_dat;
    logic        i_val;
    logic        i_eop;
    logic        i_rdy;
    logic [31:0] o_dat;
    logic        o_val;
    logic        o_eop;
    logic        o_rdy;
    logic        o_len_err;

    int n_err = 0;
    int n_chk = 0;

    logic [31:0] src_dat[$];
    logic        src_eop[$];
    logic [31:0] exp_dat[$];
    logic        exp_eop[$];
    logic [31:0] m_crc = c_seed;

    int beats, span, lerr, n_exp;

`ifdef SATA_CRC_INSERTER_LENGTH_LIMIT_EN
    sata_crc_inserter #(.MAXLEN(4)) dut (
`else
    sata_crc_inserter dut (
`endif
        .clk       (clk),
        .reset     (reset),
        .i_dat     (i_dat),
        .i_val     (i_val),
        .i_eop     (i_eop),
        .i_rdy     (i_rdy),
        .o_dat     (o_dat),
        .o_val     (o_val),
        .o_eop     (o_eop),
        .o_rdy     (o_rdy),
        .o_len_err (o_len_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_model(input logic [31:0] crc, input logic [31:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ c_poly;
            else              c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic close_frame();
        exp_dat.push_back(m_crc);
        exp_eop.push_back(1'b1);
        m_crc = c_seed;
    endtask

    task automatic add_src(input logic [31:0] d, input logic last);
        src_dat.push_back(d);
        src_eop.push_back(last);
    endtask

    task automatic add_dw(input logic [31:0] d, input logic last);
        add_src(d, last);
        exp_dat.push_back(d);
        exp_eop.push_back(1'b0);
        m_crc = crc_model(m_crc, d);
        if (last) close_frame();
    endtask

    task automatic run_stream(input int rdy_pct, input int budget,
                              output int nb, output int sp, output int le);
        int   it, first, last;
        logic hold, he, in_fire, out_fire;
        logic [31:0] hd;
        it = 0; first = -1; last = -1; hold = 1'b0; hd = '0; he = 1'b0;
        nb = 0; le = 0;
        while ((src_dat.size() > 0 || exp_dat.size() > 0) && it < budget) begin
            o_rdy = ($urandom_range(99) < rdy_pct);
            if (src_dat.size() > 0) begin
                i_val = 1'b1; i_dat = src_dat[0]; i_eop = src_eop[0];
            end else begin
                i_val = 1'b0; i_dat = '0; i_eop = 1'b0;
            end
            #1;
            if (hold) begin
                check("hold_val", o_val, 1'b1);
                check("hold_dat", o_dat, hd);
                check("hold_eop", o_eop, he);
            end
            if (o_len_err) le++;
            in_fire  = i_val & i_rdy;
            out_fire = o_val & o_rdy;
            if (out_fire) begin
                n_chk++;
                assert (exp_dat.size() != 0) else begin
                    n_err++;
                    $error("FAIL extra_beat: observed=%08h expected=none", o_dat);
                end
                if (exp_dat.size() != 0) begin
                    check("beat_dat", o_dat, exp_dat.pop_front());
                    check("beat_eop", o_eop, exp_eop.pop_front());
                end
                nb++;
                if (first < 0) first = it;
                last = it;
            end
            hold = o_val & ~o_rdy;
            hd   = o_dat;
            he   = o_eop;
            @(posedge clk); #1;
            if (in_fire) begin
                void'(src_dat.pop_front());
                void'(src_eop.pop_front());
            end
            it++;
        end
        n_chk++;
        assert (it < budget) else begin
            n_err++;
            $error("FAIL timeout: observed=%0d cycles expected=<%0d", it, budget);
        end
        src_dat.delete(); src_eop.delete(); exp_dat.delete(); exp_eop.delete();
        i_val = 1'b0; i_eop = 1'b0; i_dat = '0;
        sp = (first < 0) ? 0 : (last - first + 1);
    endtask

    initial begin
        reset = 1'b1; i_val = 1'b0; i_eop = 1'b0; i_dat = '0; o_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_val", o_val, 1'b0);
        check("rst_eop", o_eop, 1'b0);
        check("rst_dat", o_dat, 32'h0);
        check("rst_len_err", o_len_err, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_rdy", i_rdy, 1'b1);

        // 3-dword frame, full throughput
        add_dw(32'h00308027, 1'b0);
        add_dw(32'h00000000, 1'b0);
        add_dw(32'h00000000, 1'b1);
        run_stream(100, 50, beats, span, lerr);
        check("t1_beats", beats, 4);
        check("t1_span", span, 4);
        check("t1_len_err", lerr, 0);
        check("t1_idle_val", o_val, 1'b0);

        // single-dword frame
        add_dw(32'h00000000, 1'b1);
        run_stream(100, 50, beats, span, lerr);
        check("t2_beats", beats, 2);
        check("t2_span", span, 2);

        // back-to-back 2-dword frames
        add_dw(32'hDEADBEEF, 1'b0);
        add_dw(32'h01234567, 1'b1);
        add_dw(32'hFFFFFFFF, 1'b0);
        add_dw(32'hA5A55A5A, 1'b1);
        run_stream(100, 50, beats, span, lerr);
        check("t3_beats", beats, 6);
        check("t3_span", span, 6);

        // random back-pressure over random frames (lengths stay under any limit)
        for (int f = 0; f < 100; f++) begin
            int len;
            len = $urandom_range(3, 1);
            for (int k = 0; k < len; k++) add_dw($urandom(), (k == len - 1));
        end
        n_exp = exp_dat.size();
        run_stream(50, 20000, beats, span, lerr);
        check("t4_beats", beats, n_exp);
        check("t4_len_err", lerr, 0);

        // reset in the middle of a frame
        o_rdy = 1'b1;
        i_val = 1'b1; i_eop = 1'b0; i_dat = 32'h11111111;
        @(posedge clk); #1;
        i_dat = 32'h22222222;
        @(posedge clk); #1;
        check("t5_pre_val", o_val, 1'b1);
        check("t5_pre_dat", o_dat, 32'h22222222);
        reset = 1'b1; i_val = 1'b0;
        @(posedge clk); #1;
        check("t5_rst_val", o_val, 1'b0);
        check("t5_rst_dat", o_dat, 32'h0);
        reset = 1'b0;
        add_dw(32'h33333333, 1'b0);
        add_dw(32'h44444444, 1'b0);
        add_dw(32'h55555555, 1'b1);
        run_stream(100, 50, beats, span, lerr);
        check("t5_beats", beats, 4);

`ifdef SATA_CRC_INSERTER_LENGTH_LIMIT_EN
        // overrun at MAXLEN=4, tail dropped, then a normal frame
        add_dw(32'h10000001, 1'b0);
        add_dw(32'h10000002, 1'b0);
        add_dw(32'h10000003, 1'b0);
        add_dw(32'h10000004, 1'b0);
        close_frame();
        add_src(32'h10000005, 1'b0);
        add_src(32'h10000006, 1'b1);
        add_dw(32'h20000001, 1'b0);
        add_dw(32'h20000002, 1'b1);
        run_stream(100, 100, beats, span, lerr);
        check("t6_beats", beats, 8);
        check("t6_len_err", lerr, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
